// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared constants for the hazard/stall controller: forwarding-select codes and default field widths.
// Optional feature macro used by this block: HAZ_STALL_CNT_EN (stall-cycle counter).
package hazard_stall_ctrl_pkg;

    localparam int REG_W_DEF  = 5;
    localparam int TNEW_W_DEF = 3;

    // Operand source selects; FWD_RF means "take the register-file read".
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_e;

endpackage

// File: rtl/hazard_stall_ctrl_sb_stage.sv
// One scoreboard entry (hazard_sb_stage): destination, remaining Tnew and the operand addresses
// the instruction in that stage consumes. Supports bubble insertion and saturating Tnew decrement.
module hazard_sb_stage
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W    = REG_W_DEF,
    parameter int TNEW_W   = TNEW_W_DEF,
    parameter bit DEC_TNEW = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              bubble_i,
    input  logic [REG_W-1:0]  a3_i,
    input  logic [TNEW_W-1:0] tnew_i,
    input  logic [REG_W-1:0]  rs_a_i,
    input  logic              rs_use_i,
    input  logic [REG_W-1:0]  rt_a_i,
    input  logic              rt_use_i,
    output logic [REG_W-1:0]  a3_o,
    output logic [TNEW_W-1:0] tnew_o,
    output logic [REG_W-1:0]  rs_a_o,
    output logic              rs_use_o,
    output logic [REG_W-1:0]  rt_a_o,
    output logic              rt_use_o
);

    logic [REG_W-1:0]  a3_q,   a3_d;
    logic [TNEW_W-1:0] tnew_q, tnew_d;
    logic [REG_W-1:0]  rs_a_q, rs_a_d;
    logic              rs_use_q, rs_use_d;
    logic [REG_W-1:0]  rt_a_q, rt_a_d;
    logic              rt_use_q, rt_use_d;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
        if (t == {TNEW_W{1'b0}}) begin
            sat_dec = {TNEW_W{1'b0}};
        end else begin
            sat_dec = t - {{(TNEW_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Next-state: a bubble clears the whole entry, otherwise capture the upstream instruction.
    always_comb begin
        a3_d     = a3_q;
        tnew_d   = tnew_q;
        rs_a_d   = rs_a_q;
        rs_use_d = rs_use_q;
        rt_a_d   = rt_a_q;
        rt_use_d = rt_use_q;
        if (bubble_i) begin
            a3_d     = {REG_W{1'b0}};
            tnew_d   = {TNEW_W{1'b0}};
            rs_a_d   = {REG_W{1'b0}};
            rs_use_d = 1'b0;
            rt_a_d   = {REG_W{1'b0}};
            rt_use_d = 1'b0;
        end else begin
            a3_d     = a3_i;
            rs_a_d   = rs_a_i;
            rs_use_d = rs_use_i;
            rt_a_d   = rt_a_i;
            rt_use_d = rt_use_i;
            if (DEC_TNEW) begin
                tnew_d = sat_dec(tnew_i);
            end else begin
                tnew_d = tnew_i;
            end
        end
    end

    // Entry register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a3_q     <= {REG_W{1'b0}};
            tnew_q   <= {TNEW_W{1'b0}};
            rs_a_q   <= {REG_W{1'b0}};
            rs_use_q <= 1'b0;
            rt_a_q   <= {REG_W{1'b0}};
            rt_use_q <= 1'b0;
        end else begin
            a3_q     <= a3_d;
            tnew_q   <= tnew_d;
            rs_a_q   <= rs_a_d;
            rs_use_q <= rs_use_d;
            rt_a_q   <= rt_a_d;
            rt_use_q <= rt_use_d;
        end
    end

    assign a3_o     = a3_q;
    assign tnew_o   = tnew_q;
    assign rs_a_o   = rs_a_q;
    assign rs_use_o = rs_use_q;
    assign rt_a_o   = rt_a_q;
    assign rt_use_o = rt_use_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Tuse/Tnew hazard controller: E/M/W writer scoreboard, D-stage stall/flush and forwarding selects.
// Define HAZ_STALL_CNT_EN to build the saturating stall-cycle counter; otherwise stall_cnt reads zero.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W  = REG_W_DEF,
    parameter int TNEW_W = TNEW_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  D_A1,
    input  logic              D_rs_use,
    input  logic [TNEW_W-1:0] D_rsTuse,
    input  logic [REG_W-1:0]  D_A2,
    input  logic              D_rt_use,
    input  logic [TNEW_W-1:0] D_rtTuse,
    input  logic [REG_W-1:0]  D_A3,
    input  logic [TNEW_W-1:0] D_Tnew,
    output logic              stall,
    output logic              E_flush,
    output logic [1:0]        fwd_D_rs,
    output logic [1:0]        fwd_D_rt,
    output logic [1:0]        fwd_E_rs,
    output logic [1:0]        fwd_E_rt,
    output logic [1:0]        fwd_M_rt,
    output logic [31:0]       stall_cnt
);

    logic [REG_W-1:0]  e_a3_s, m_a3_s, w_a3_s;
    logic [TNEW_W-1:0] e_tnew_s, m_tnew_s, w_tnew_s;
    logic [REG_W-1:0]  e_rs_a_s, e_rt_a_s, m_rt_a_s;
    logic              e_rs_use_s, e_rt_use_s, m_rt_use_s;
    logic [REG_W-1:0]  m_rs_a_unused_s, w_rs_a_unused_s, w_rt_a_unused_s;
    logic              m_rs_use_unused_s, w_rs_use_unused_s, w_rt_use_unused_s;
    logic              stall_s;
    logic [1:0]        fwd_d_rs_s, fwd_d_rt_s, fwd_e_rs_s, fwd_e_rt_s, fwd_m_rt_s;

    // E captures D_Tnew as-is; M and W age it by one cycle on the way in.
    hazard_sb_stage #(.REG_W(REG_W), .TNEW_W(TNEW_W), .DEC_TNEW(1'b0)) u_sb_e (
        .clk_i    (clk),        .rst_n_i  (reset),     .bubble_i (stall_s),
        .a3_i     (D_A3),       .tnew_i   (D_Tnew),
        .rs_a_i   (D_A1),       .rs_use_i (D_rs_use),
        .rt_a_i   (D_A2),       .rt_use_i (D_rt_use),
        .a3_o     (e_a3_s),     .tnew_o   (e_tnew_s),
        .rs_a_o   (e_rs_a_s),   .rs_use_o (e_rs_use_s),
        .rt_a_o   (e_rt_a_s),   .rt_use_o (e_rt_use_s)
    );

    hazard_sb_stage #(.REG_W(REG_W), .TNEW_W(TNEW_W), .DEC_TNEW(1'b1)) u_sb_m (
        .clk_i    (clk),        .rst_n_i  (reset),     .bubble_i (1'b0),
        .a3_i     (e_a3_s),     .tnew_i   (e_tnew_s),
        .rs_a_i   ({REG_W{1'b0}}), .rs_use_i (1'b0),
        .rt_a_i   (e_rt_a_s),   .rt_use_i (e_rt_use_s),
        .a3_o     (m_a3_s),     .tnew_o   (m_tnew_s),
        .rs_a_o   (m_rs_a_unused_s), .rs_use_o (m_rs_use_unused_s),
        .rt_a_o   (m_rt_a_s),   .rt_use_o (m_rt_use_s)
    );

    hazard_sb_stage #(.REG_W(REG_W), .TNEW_W(TNEW_W), .DEC_TNEW(1'b1)) u_sb_w (
        .clk_i    (clk),        .rst_n_i  (reset),     .bubble_i (1'b0),
        .a3_i     (m_a3_s),     .tnew_i   (m_tnew_s),
        .rs_a_i   ({REG_W{1'b0}}), .rs_use_i (1'b0),
        .rt_a_i   ({REG_W{1'b0}}), .rt_use_i (1'b0),
        .a3_o     (w_a3_s),     .tnew_o   (w_tnew_s),
        .rs_a_o   (w_rs_a_unused_s), .rs_use_o (w_rs_use_unused_s),
        .rt_a_o   (w_rt_a_unused_s), .rt_use_o (w_rt_use_unused_s)
    );

    logic unused_s;
    assign unused_s = ^{m_rs_a_unused_s, m_rs_use_unused_s, w_rs_a_unused_s,
                        w_rs_use_unused_s, w_rt_a_unused_s, w_rt_use_unused_s};

    function automatic logic addr_match(input logic [REG_W-1:0] x, input logic [REG_W-1:0] a3);
        addr_match = (x != {REG_W{1'b0}}) && (x == a3);
    endfunction

    function automatic logic needs_stall(input logic use_i, input logic [REG_W-1:0] addr,
                                         input logic [TNEW_W-1:0] tuse,
                                         input logic [REG_W-1:0] a3, input logic [TNEW_W-1:0] tnew);
        needs_stall = use_i && addr_match(addr, a3) && (tuse < tnew);
    endfunction

    // Youngest matching enabled stage decides; a not-yet-ready match shadows older stages.
    function automatic logic [1:0] fwd_pick(
        input logic use_i, input logic [REG_W-1:0] addr,
        input logic e_en, input logic [REG_W-1:0] e_a3, input logic [TNEW_W-1:0] e_t,
        input logic m_en, input logic [REG_W-1:0] m_a3, input logic [TNEW_W-1:0] m_t,
        input logic [REG_W-1:0] w_a3, input logic [TNEW_W-1:0] w_t);
        logic [1:0] sel;
        sel = FWD_RF;
        if (!use_i) begin
            sel = FWD_RF;
        end else if (e_en && addr_match(addr, e_a3)) begin
            sel = (e_t == {TNEW_W{1'b0}}) ? FWD_E : FWD_RF;
        end else if (m_en && addr_match(addr, m_a3)) begin
            sel = (m_t == {TNEW_W{1'b0}}) ? FWD_M : FWD_RF;
        end else if (addr_match(addr, w_a3)) begin
            sel = (w_t == {TNEW_W{1'b0}}) ? FWD_W : FWD_RF;
        end else begin
            sel = FWD_RF;
        end
        fwd_pick = sel;
    endfunction

    // Stall detection and forwarding selects, purely combinational from D inputs and scoreboard.
    always_comb begin
        stall_s = needs_stall(D_rs_use, D_A1, D_rsTuse, e_a3_s, e_tnew_s)
                | needs_stall(D_rs_use, D_A1, D_rsTuse, m_a3_s, m_tnew_s)
                | needs_stall(D_rt_use, D_A2, D_rtTuse, e_a3_s, e_tnew_s)
                | needs_stall(D_rt_use, D_A2, D_rtTuse, m_a3_s, m_tnew_s);
        fwd_d_rs_s = fwd_pick(D_rs_use, D_A1, 1'b1, e_a3_s, e_tnew_s, 1'b1, m_a3_s, m_tnew_s,
                              w_a3_s, w_tnew_s);
        fwd_d_rt_s = fwd_pick(D_rt_use, D_A2, 1'b1, e_a3_s, e_tnew_s, 1'b1, m_a3_s, m_tnew_s,
                              w_a3_s, w_tnew_s);
        fwd_e_rs_s = fwd_pick(e_rs_use_s, e_rs_a_s, 1'b0, e_a3_s, e_tnew_s, 1'b1, m_a3_s, m_tnew_s,
                              w_a3_s, w_tnew_s);
        fwd_e_rt_s = fwd_pick(e_rt_use_s, e_rt_a_s, 1'b0, e_a3_s, e_tnew_s, 1'b1, m_a3_s, m_tnew_s,
                              w_a3_s, w_tnew_s);
        fwd_m_rt_s = fwd_pick(m_rt_use_s, m_rt_a_s, 1'b0, e_a3_s, e_tnew_s, 1'b0, m_a3_s, m_tnew_s,
                              w_a3_s, w_tnew_s);
    end

    assign stall    = stall_s;
    assign E_flush  = stall_s;
    assign fwd_D_rs = fwd_d_rs_s;
    assign fwd_D_rt = fwd_d_rt_s;
    assign fwd_E_rs = fwd_e_rs_s;
    assign fwd_E_rt = fwd_e_rt_s;
    assign fwd_M_rt = fwd_m_rt_s;

`ifdef HAZ_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of clock edges seen while stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter register, cleared asynchronously with the scoreboard.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Table-driven bench for hazard_stall_ctrl: per-cycle D-stage vectors with expected stall/forward
// selects pushed to a scoreboard queue, plus hand sequences for reset-during-stall and the counter.
module tb_hazard_stall_ctrl;

    logic       clk, reset;
    logic [4:0] D_A1, D_A2, D_A3;
    logic       D_rs_use, D_rt_use;
    logic [2:0] D_rsTuse, D_rtTuse, D_Tnew;
    logic       stall, E_flush;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt;
    logic [31:0] stall_cnt;

    hazard_stall_ctrl #(.REG_W(5), .TNEW_W(3)) dut (
        .clk(clk), .reset(reset),
        .D_A1(D_A1), .D_rs_use(D_rs_use), .D_rsTuse(D_rsTuse),
        .D_A2(D_A2), .D_rt_use(D_rt_use), .D_rtTuse(D_rtTuse),
        .D_A3(D_A3), .D_Tnew(D_Tnew),
        .stall(stall), .E_flush(E_flush),
        .fwd_D_rs(fwd_D_rs), .fwd_D_rt(fwd_D_rt), .fwd_E_rs(fwd_E_rs),
        .fwd_E_rt(fwd_E_rt), .fwd_M_rt(fwd_M_rt), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] a1; logic u1; logic [2:0] t1;
        logic [4:0] a2; logic u2; logic [2:0] t2;
        logic [4:0] a3; logic [2:0] tn;
        logic st;
        logic [1:0] drs, drt, ers, ert, mrt;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[25];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;

    function automatic vec_t mk(input logic [4:0] a1, input logic u1, input logic [2:0] t1,
                                input logic [4:0] a2, input logic u2, input logic [2:0] t2,
                                input logic [4:0] a3, input logic [2:0] tn, input logic st,
                                input logic [1:0] drs, input logic [1:0] drt, input logic [1:0] ers,
                                input logic [1:0] ert, input logic [1:0] mrt);
        vec_t v;
        v.a1 = a1; v.u1 = u1; v.t1 = t1; v.a2 = a2; v.u2 = u2; v.t2 = t2;
        v.a3 = a3; v.tn = tn; v.st = st;
        v.drs = drs; v.drt = drt; v.ers = ers; v.ert = ert; v.mrt = mrt;
        return v;
    endfunction

    function automatic logic [31:0] cnt_model();
`ifdef HAZ_STALL_CNT_EN
        return 32'(exp_cnt);
`else
        return 32'd0;
`endif
    endfunction

    task automatic cmp(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s got %0h want %0h", tag, what, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        D_A1 = v.a1; D_rs_use = v.u1; D_rsTuse = v.t1;
        D_A2 = v.a2; D_rt_use = v.u2; D_rtTuse = v.t2;
        D_A3 = v.a3; D_Tnew = v.tn;
        exp_q.push_back(v);
    endtask

    task automatic check_out(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s.queue got empty want entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, "stall",    {31'd0, stall},    {31'd0, e.st});
            cmp(tag, "E_flush",  {31'd0, E_flush},  {31'd0, e.st});
            cmp(tag, "fwd_D_rs", {30'd0, fwd_D_rs}, {30'd0, e.drs});
            cmp(tag, "fwd_D_rt", {30'd0, fwd_D_rt}, {30'd0, e.drt});
            cmp(tag, "fwd_E_rs", {30'd0, fwd_E_rs}, {30'd0, e.ers});
            cmp(tag, "fwd_E_rt", {30'd0, fwd_E_rt}, {30'd0, e.ert});
            cmp(tag, "fwd_M_rt", {30'd0, fwd_M_rt}, {30'd0, e.mrt});
            cmp(tag, "stall_cnt", stall_cnt, cnt_model());
            if (e.st) exp_cnt++;
        end
    endtask

    task automatic step(input vec_t v, input string tag);
        @(posedge clk); #1;
        drive(v);
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic check_cleared(input string tag);
        cmp(tag, "stall",    {31'd0, stall},    32'd0);
        cmp(tag, "E_flush",  {31'd0, E_flush},  32'd0);
        cmp(tag, "fwd_D_rs", {30'd0, fwd_D_rs}, 32'd0);
        cmp(tag, "fwd_D_rt", {30'd0, fwd_D_rt}, 32'd0);
        cmp(tag, "fwd_E_rs", {30'd0, fwd_E_rs}, 32'd0);
        cmp(tag, "fwd_E_rt", {30'd0, fwd_E_rt}, 32'd0);
        cmp(tag, "fwd_M_rt", {30'd0, fwd_M_rt}, 32'd0);
        cmp(tag, "stall_cnt", stall_cnt, 32'd0);
    endtask

    initial begin
        vec_t nop_v, lw_v, use_v, use2_v;
        //            a1 u1 t1 a2 u2 t2 a3 tn  st drs drt ers ert mrt
        tbl[0]  = mk(29, 1, 1, 0, 0, 0, 8, 2, 0, 0, 0, 0, 0, 0); // lw $8
        tbl[1]  = mk( 8, 1, 1, 8, 1, 1, 9, 1, 1, 0, 0, 0, 0, 0); // addu $9,$8,$8 stalls
        tbl[2]  = mk( 8, 1, 1, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0, 0); // held, M shadows
        tbl[3]  = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 3, 0); // addu in E gets W
        tbl[4]  = mk( 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0); // lui $1
        tbl[5]  = mk( 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); // beq $1,$0 -> FWD_E
        tbl[6]  = mk( 2, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 2, 0, 0); // addu $3; beq in E gets M
        tbl[7]  = mk( 3, 1, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // beq $3,$3 stalls
        tbl[8]  = mk( 3, 1, 0, 3, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0); // then FWD_M both
        tbl[9]  = mk( 9, 1, 1, 0, 0, 0, 8, 2, 0, 0, 0, 3, 3, 0); // lw $8; beq in E gets W
        tbl[10] = mk( 9, 1, 1, 8, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0); // sw $8,0($9) no stall
        tbl[11] = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // sw in E, M shadows
        tbl[12] = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3); // sw in M -> FWD_W
        tbl[13] = mk( 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0); // writer to $0
        tbl[14] = mk( 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // reader of $0
        tbl[15] = mk( 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0); // lui $5 x3
        tbl[16] = mk( 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk( 0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        tbl[18] = mk( 5, 1, 1, 0, 1, 1, 6, 1, 0, 1, 0, 0, 0, 0); // E beats M and W
        tbl[19] = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0); // E consumer: M beats W
        tbl[20] = mk( 5, 1, 0, 6, 1, 0, 0, 0, 0, 3, 2, 0, 0, 0); // D: W for rs, M for rt
        tbl[21] = mk( 0, 0, 0, 0, 0, 0, 7, 2, 0, 0, 0, 0, 3, 0); // lw $7
        tbl[22] = mk( 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[23] = mk( 7, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0); // M lw tnew1 > tuse0
        tbl[24] = mk( 7, 1, 0, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0, 0); // then FWD_W

        nop_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        D_A1 = 5'd0; D_rs_use = 1'b0; D_rsTuse = 3'd0;
        D_A2 = 5'd0; D_rt_use = 1'b0; D_rtTuse = 3'd0;
        D_A3 = 5'd0; D_Tnew = 3'd0;
        repeat (2) @(negedge clk);
        check_cleared("reset");
        reset = 1'b1;

        for (int i = 0; i < 25; i++) begin
            step(tbl[i], $sformatf("v%0d", i));
        end

        // Stall from E lw on rs while rt forwards from M, then reset mid-cycle.
        step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), "rst_a");
        step(mk(0, 0, 0, 0, 0, 0, 8, 2, 0, 0, 0, 0, 0, 0), "rst_b");
        step(mk(8, 1, 1, 1, 1, 1, 9, 1, 1, 0, 2, 0, 0, 0), "rst_c");
        #2;
        reset = 1'b0;
        D_A1 = 5'd0; D_rs_use = 1'b0; D_A2 = 5'd0; D_rt_use = 1'b0; D_A3 = 5'd0; D_Tnew = 3'd0;
        exp_cnt = 0;
        #1;
        check_cleared("rst_mid");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Three back-to-back lw-use pairs after reset.
        lw_v   = mk(29, 1, 1, 0, 0, 0, 8, 2, 0, 0, 0, 0, 0, 0);
        use_v  = mk( 8, 1, 1, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0);
        use2_v = mk( 8, 1, 1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        for (int p = 0; p < 3; p++) begin
            lw_v.ers = (p == 0) ? 2'd0 : 2'd3;
            step(lw_v,   $sformatf("pair%0d_lw", p));
            step(use_v,  $sformatf("pair%0d_use", p));
            step(use2_v, $sformatf("pair%0d_use2", p));
        end
        nop_v.ers = 2'd3;
        step(nop_v, "pairs_end");
`ifdef HAZ_STALL_CNT_EN
        cmp("pairs", "stall_cnt_total", stall_cnt, 32'd3);
`else
        cmp("pairs", "stall_cnt_total", stall_cnt, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
